mmio_rd_ctrl: RTL
=================

Name: mmio_rd_ctrl

Overview:
Read-side memory-mapped I/O responder for the cpu_v3 data bus, the counterpart of the write-side display sink. It answers CPU load requests from a small register window with one-cycle latency. The window exposes synchronized board switches, a free-running cycle counter and a debounced button-press event counter. It sits beside the write controller on the same addr/clk bus and feeds the CPU load-data mux.

Parameters:
BASE_ADDR, 32'h20, byte address of register 0; window is 4 words, BASE_ADDR..BASE_ADDR+0xC.
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a button level change; legal range 1..255.

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
addr  input  32  CPU byte address of the load
re  input  1  read request, sampled on rising clk edge
sw  input  16  asynchronous board switches
btn  input  1  asynchronous push button, active-high
data_out  output  32  read data, valid when valid=1
valid  output  1  one-cycle pulse: data_out holds response to previous-cycle request
err  output  1  one-cycle pulse with valid: request address was outside the window

Behaviour:
- Reset (async, rst=1): data_out=0, valid=0, err=0, cycle counter=0, event count=0, sync flops=0, debounced button=0, debounce counter=0.
- Register map, word index = (addr - BASE_ADDR)>>2; addr[1:0] ignored:
  - +0x0 SW: {16'b0, sw_sync}. sw_sync is sw after a 2-flop synchronizer.
  - +0x4 CYCLES: 32-bit free-running counter, +1 every cycle out of reset, wraps FFFFFFFF->0.
  - +0x8 EVT: {24'b0, evt_cnt}; clear-on-read.
  - +0xC STATUS: {30'b0, sat, pend}; pend = (evt_cnt != 0), sat = (evt_cnt == 8'hFF).
- Request acceptance: re=1 at edge N gives valid=1 at edge N+1, with data_out = register value sampled at edge N.
  - CYCLES returns the counter value before its edge-N increment.
  - Back-to-back requests are allowed every cycle; no stall and no backpressure.
- re=0: valid=0, err=0, data_out holds its last value.
- Out-of-window address (below BASE_ADDR or above BASE_ADDR+0xF): valid=1, err=1, data_out=32'h0. No side effects.
- Button path:
  - btn passes through a 2-flop synchronizer to btn_s.
  - Debounce counter resets to 0 whenever btn_s equals the debounced level.
  - Otherwise the counter increments each cycle. When it reaches DEBOUNCE_CYCLES, the debounced level takes btn_s and the counter clears.
  - A 0->1 transition of the debounced level is one press event.
- evt_cnt: 8-bit, +1 per press event, saturates at 255.
- EVT read (re=1 at EVT address at edge N):
  - Returns pre-clear value.
  - evt_cnt becomes 0 at edge N, or 1 if a press event occurs in the same cycle. No event is lost and none is counted twice.
  - A read of STATUS does not clear.
- Press events at saturation are dropped; sat stays 1 until an EVT read.
- Latency from btn rising to evt_cnt increment: 2 sync cycles + DEBOUNCE_CYCLES cycles, +/-1 for the sampling phase.
- Reset asserted mid-request: valid drops to 0 immediately (async). A request pending on that edge is discarded.

Test Plan:
- Reset: rst=1 then release; read +4 at the first cycle -> valid next cycle, data_out=0x00000000; read +4 again 5 cycles later -> data_out=0x00000005.
- Switch sync: sw=16'hA5C3, wait 2 cycles, re at addr 0x20 -> data_out=0x0000A5C3, err=0; also read addr 0x23 -> same value.
- Debounce and clear-on-read: 3 clean presses, each 10 cycles high and 10 low, DEBOUNCE_CYCLES=4; STATUS read -> 0x1; EVT read -> 0x3; EVT read again -> 0x0.
- Glitch reject: btn high for 3 cycles only -> EVT read -> 0x0.
- Saturation and collision: 260 presses -> STATUS -> 0x3, EVT -> 0xFF. Then align a press event with an EVT read cycle -> read returns the old value and the next EVT read returns 0x1.
- Errors and wrap: read addr 0x1C and 0x30 -> valid=1, err=1, data_out=0. Force CYCLES near FFFFFFFE via a long run or bench force, then read consecutively -> FFFFFFFE, FFFFFFFF, 00000000. Assert rst while re=1 -> valid=0 immediately.

Source files
------------

// File: rtl/mmio_rd_ctrl.sv
// Read-side MMIO responder: switches, free-running cycle counter and debounced button-press events.
// Latency: one cycle from request (re sampled at edge N) to valid/err/data_out at edge N+1.
// Backpressure: none; a new request may be issued every cycle and is always answered.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   addr, re      CPU load byte address and read request
//   sw, btn       asynchronous board switches and push button (synchronized internally)
//   data_out      read data, updated only when a request is answered
//   valid, err    one-cycle response pulse; err flags an address outside the 4-word window
module mmio_rd_ctrl #(
    parameter logic [31:0] BASE_ADDR       = 32'h20,
    parameter int          DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        re,
    input  logic [15:0] sw,
    input  logic        btn,
    output logic [31:0] data_out,
    output logic        valid,
    output logic        err
);

    localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

    logic [15:0] sw_meta;
    logic [15:0] sw_sync;
    logic        btn_meta;
    logic        btn_s;
    logic        btn_db;
    logic [7:0]  db_cnt;
    logic [7:0]  db_cnt_inc;
    logic        settle;
    logic        press;
    logic [31:0] cyc_cnt;
    logic [7:0]  evt_cnt;
    logic [31:0] offset;
    logic        in_win;
    logic [1:0]  idx;
    logic        evt_rd;
    logic [31:0] rd_val;
    logic        unused_addr_bits;

    // Address decode. Testing addr >= BASE_ADDR first keeps the subtraction
    // from wrapping, so a small offset really means "inside the window".
    assign offset           = addr - BASE_ADDR;
    assign in_win           = (addr >= BASE_ADDR) && (offset[31:4] == 28'd0);
    assign idx              = offset[3:2];
    assign unused_addr_bits = ^offset[1:0];

    // Two-flop synchronizers for the asynchronous board inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            btn_meta <= btn;
            btn_s    <= btn_meta;
        end
    end

    // Debounce: the level is accepted on the cycle the run of mismatching
    // samples reaches DEBOUNCE_CYCLES. The press event is flagged on that
    // same edge so the event counter updates together with the level.
    assign db_cnt_inc = db_cnt + 8'd1;
    assign settle     = (btn_s != btn_db) && (db_cnt_inc == DB_LIMIT);
    assign press      = settle && btn_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_db <= 1'b0;
            db_cnt <= 8'd0;
        end else if (btn_s == btn_db) begin
            db_cnt <= 8'd0;
        end else if (settle) begin
            btn_db <= btn_s;
            db_cnt <= 8'd0;
        end else begin
            db_cnt <= db_cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt <= 32'd0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
        end
    end

    // Clear-on-read event counter. A press coinciding with the clearing read
    // is kept as the first event of the next period rather than lost.
    assign evt_rd = re && in_win && (idx == 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_cnt <= 8'd0;
        end else if (evt_rd) begin
            evt_cnt <= press ? 8'd1 : 8'd0;
        end else if (press && (evt_cnt != 8'hFF)) begin
            evt_cnt <= evt_cnt + 8'd1;
        end
    end

    always_comb begin
        rd_val = 32'd0;
        case (idx)
            2'd0: rd_val = {16'd0, sw_sync};
            2'd1: rd_val = cyc_cnt;
            2'd2: rd_val = {24'd0, evt_cnt};
            2'd3: rd_val = {30'd0, (evt_cnt == 8'hFF), (evt_cnt != 8'd0)};
            default: rd_val = 32'd0;
        endcase
    end

    // Response register. data_out is left untouched on idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= 32'd0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            valid <= re;
            err   <= re && !in_win;
            if (re) begin
                data_out <= in_win ? rd_val : 32'd0;
            end
        end
    end

endmodule
